// File: rtl/ahb_master_arb.sv
// Round-robin arbitrated AHB-Lite master issuing single, non-pipelined transfers.
// Optional data-phase watchdog is enabled with `define AHB_MASTER_ARB_TIMEOUT_EN.
module ahb_master_arb #(
    parameter int AHB_DW  = 32,
    parameter int AHB_AW  = 32,
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*AHB_AW-1:0] req_addr,
    input  logic [NUM_REQ*AHB_DW-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]      req_size,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [AHB_DW-1:0]         rdata,
    output logic                      busy,
    output logic                      timeout,
    output logic [AHB_AW-1:0]         haddr,
    output logic [AHB_DW-1:0]         hwdata,
    output logic [2:0]                hburst,
    output logic [2:0]                hsize,
    output logic                      hwrite,
    output logic [1:0]                htrans,
    input  logic                      hready,
    input  logic [AHB_DW-1:0]         hrdata
);

    localparam int MAX_SIZE = $clog2(AHB_DW / 8);
    localparam int IDXW     = $clog2(NUM_REQ);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   last_gnt;
    logic [IDXW-1:0]   cur;
    logic [AHB_DW-1:0] wdata_q;

    logic [IDXW-1:0]   cand;
    logic [IDXW-1:0]   winner;
    logic              found;
    logic [2:0]        raw_size;
    logic [2:0]        win_size;
    logic [AHB_AW-1:0] win_addr;

    assign hburst = 3'b000;

    // Search upward from the requester after the last grant, wrapping around.
    always_comb begin
        cand   = last_gnt;
        winner = last_gnt;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDXW'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Oversized hsize codes are clamped to the bus width, then the address is aligned to it.
    always_comb begin
        raw_size = req_size[winner*3 +: 3];
        win_size = (raw_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : raw_size;
        win_addr = req_addr[winner*AHB_AW +: AHB_AW]
                   & ~((AHB_AW'(1) << win_size) - AHB_AW'(1));
    end

`ifdef AHB_MASTER_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= IDXW'(NUM_REQ - 1);
            cur      <= '0;
            wdata_q  <= '0;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            haddr    <= '0;
            hwdata   <= '0;
            hsize    <= 3'b000;
            hwrite   <= 1'b0;
            htrans   <= HTRANS_IDLE;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done <= '0;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= ADDR;
                        cur     <= winner;
                        gnt     <= NUM_REQ'(1) << winner;
                        busy    <= 1'b1;
                        htrans  <= HTRANS_NONSEQ;
                        haddr   <= win_addr;
                        hwrite  <= req_write[winner];
                        hsize   <= win_size;
                        wdata_q <= req_wdata[winner*AHB_DW +: AHB_DW];
                    end
                end
                ADDR: begin
                    if (hready) begin
                        state  <= DATA;
                        htrans <= HTRANS_IDLE;
                        hwdata <= wdata_q;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                DATA: begin
                    if (hready) begin
                        state    <= IDLE;
                        done     <= NUM_REQ'(1) << cur;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        last_gnt <= cur;
                        if (!hwrite) begin
                            rdata <= hrdata;
                        end
                    end
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        done      <= NUM_REQ'(1) << cur;
                        gnt       <= '0;
                        busy      <= 1'b0;
                        last_gnt  <= cur;
                        rdata     <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_arb.sv
// Self-checking bench for ahb_master_arb: directed scenarios then randomized transfers
// checked against a transfer-level round-robin model.
module tb_ahb_master_arb;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 2;
    localparam int TO = 4;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*3-1:0]  req_size;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [DW-1:0]    rdata;
    logic             busy;
    logic             timeout;
    logic [AW-1:0]    haddr;
    logic [DW-1:0]    hwdata;
    logic [2:0]       hburst;
    logic [2:0]       hsize;
    logic             hwrite;
    logic [1:0]       htrans;
    logic             hready;
    logic [DW-1:0]    hrdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mAddr [NR];
    logic [2:0]  mSize [NR];
    logic        mWrite[NR];
    logic [31:0] mWdata[NR];
    int          lastGnt;
    logic [31:0] expRdata;

    ahb_master_arb #(
        .AHB_DW (DW),
        .AHB_AW (AW),
        .NUM_REQ(NR),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_size (req_size),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .busy     (busy),
        .timeout  (timeout),
        .haddr    (haddr),
        .hwdata   (hwdata),
        .hburst   (hburst),
        .hsize    (hsize),
        .hwrite   (hwrite),
        .htrans   (htrans),
        .hready   (hready),
        .hrdata   (hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int modelWinner(input logic [NR-1:0] mask);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(lastGnt + k) % NR]) return (lastGnt + k) % NR;
        end
        return -1;
    endfunction

    function automatic int clampSize(input logic [2:0] s);
        return (s > 3'd2) ? 2 : int'(s);
    endfunction

    task automatic applyStimulus(input int i, input logic wr, input logic [31:0] a,
                                 input logic [2:0] sz, input logic [31:0] wd);
        mAddr[i] = a;
        mSize[i] = sz;
        mWrite[i] = wr;
        mWdata[i] = wd;
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_size[i*3 +: 3] = sz;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic runTransfer(input logic [NR-1:0] mask, input int addrWaits, input int dataWaits,
                               input logic [31:0] rd, input bit dropReq);
        int w;
        int sz;
        logic [31:0] ea;
        w = modelWinner(mask);
        sz = clampSize(mSize[w]);
        ea = mAddr[w] - (mAddr[w] % (32'd1 << sz));
        req = mask;
        @(negedge clk);
        checkOutput("addr_gnt", gnt, NR'(1) << w);
        checkOutput("addr_busy", busy, 1);
        checkOutput("addr_htrans", htrans, 2'b10);
        checkOutput("addr_haddr", haddr, ea);
        checkOutput("addr_hsize", hsize, sz);
        checkOutput("addr_hwrite", hwrite, mWrite[w]);
        checkOutput("addr_hburst", hburst, 0);
        checkOutput("addr_done", done, 0);
        if (dropReq) req = '0;
        for (int i = 0; i < addrWaits; i++) begin
            hready = 1'b0;
            @(negedge clk);
            checkOutput("addrwait_htrans", htrans, 2'b10);
            checkOutput("addrwait_haddr", haddr, ea);
            checkOutput("addrwait_gnt", gnt, NR'(1) << w);
        end
        hready = 1'b1;
        @(negedge clk);
        checkOutput("data_htrans", htrans, 2'b00);
        checkOutput("data_hwdata", hwdata, mWdata[w]);
        checkOutput("data_haddr", haddr, ea);
        checkOutput("data_busy", busy, 1);
        checkOutput("data_done", done, 0);
        for (int i = 0; i < dataWaits; i++) begin
            hready = 1'b0;
            hrdata = $urandom;
            @(negedge clk);
            checkOutput("datawait_htrans", htrans, 2'b00);
            checkOutput("datawait_hwdata", hwdata, mWdata[w]);
            checkOutput("datawait_done", done, 0);
            checkOutput("datawait_gnt", gnt, NR'(1) << w);
        end
        hready = 1'b1;
        hrdata = rd;
        @(negedge clk);
        if (!mWrite[w]) expRdata = rd;
        lastGnt = w;
        checkOutput("end_done", done, NR'(1) << w);
        checkOutput("end_rdata", rdata, expRdata);
        checkOutput("end_gnt", gnt, 0);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_timeout", timeout, 0);
        req = '0;
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        req_size = '0;
        hready = 1'b1;
        hrdata = '0;
        lastGnt = NR - 1;
        expRdata = '0;
        for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 32'h0, 3'd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_haddr", haddr, 0);
        checkOutput("rst_hwdata", hwdata, 0);
        checkOutput("rst_hsize", hsize, 0);
        checkOutput("rst_hwrite", hwrite, 0);
        checkOutput("rst_htrans", htrans, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single zero-wait write from requester 0
        applyStimulus(0, 1'b1, 32'h0000_1004, 3'd2, 32'hDEAD_BEEF);
        runTransfer(2'b01, 0, 0, 32'h0, 1'b0);

        // Read from requester 1 with two data-phase wait states
        applyStimulus(1, 1'b0, 32'h0000_2000, 3'd2, 32'h0);
        runTransfer(2'b10, 0, 2, 32'h1234_5678, 1'b0);

        // Both requesting continuously: grants must alternate
        applyStimulus(0, 1'b1, 32'h0000_0100, 3'd2, 32'hAAAA_0000);
        applyStimulus(1, 1'b0, 32'h0000_0200, 3'd1, 32'hBBBB_0000);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr_order", modelWinner(2'b11), i % 2);
            runTransfer(2'b11, 0, 0, 32'hC000_0000 + i, 1'b0);
        end

        // Address alignment and size clamping
        applyStimulus(0, 1'b1, 32'h0000_1003, 3'd2, 32'h1111_2222);
        runTransfer(2'b01, 1, 0, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0000_2007, 3'd3, 32'h0);
        runTransfer(2'b10, 0, 1, 32'h5555_AAAA, 1'b0);

        // Data phase stalled indefinitely by the slave
        applyStimulus(1, 1'b0, 32'h0000_3000, 3'd2, 32'h0);
        req = 2'b10;
        @(negedge clk);
        checkOutput("stall_gnt", gnt, 2'b10);
        hready = 1'b1;
        @(negedge clk);
        req = '0;
        hready = 1'b0;
`ifdef AHB_MASTER_ARB_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            checkOutput("stall_timeout_early", timeout, 0);
            checkOutput("stall_busy_early", busy, 1);
        end
        @(negedge clk);
        expRdata = '0;
        lastGnt = 1;
        checkOutput("to_timeout", timeout, 1);
        checkOutput("to_done", done, 2'b10);
        checkOutput("to_rdata", rdata, 0);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_gnt", gnt, 0);
        @(negedge clk);
        checkOutput("to_pulse_end", timeout, 0);
        checkOutput("to_done_end", done, 0);
        hready = 1'b1;
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_busy", busy, 1);
            checkOutput("stall_done", done, 0);
            checkOutput("stall_timeout", timeout, 0);
        end
        hready = 1'b1;
        hrdata = 32'h0BAD_F00D;
        @(negedge clk);
        expRdata = 32'h0BAD_F00D;
        lastGnt = 1;
        checkOutput("stall_end_done", done, 2'b10);
        checkOutput("stall_end_rdata", rdata, expRdata);
`endif

        // Reset asserted during the data phase
        applyStimulus(0, 1'b0, 32'h0000_4000, 3'd2, 32'h7777_8888);
        req = 2'b01;
        @(negedge clk);
        hready = 1'b1;
        @(negedge clk);
        hready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_htrans", htrans, 0);
        checkOutput("midrst_gnt", gnt, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_rdata", rdata, 0);
        req = '0;
        hready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lastGnt = NR - 1;
        expRdata = '0;
        @(negedge clk);
        checkOutput("postrst_done", done, 0);
        applyStimulus(1, 1'b0, 32'h0000_5000, 3'd2, 32'h0);
        runTransfer(2'b11, 0, 0, 32'h2468_ACE0, 1'b0);
        checkOutput("postrst_winner", lastGnt, 0);

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                applyStimulus(i, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), $urandom);
            end
            runTransfer(NR'($urandom_range(1, 3)), $urandom_range(0, 2), $urandom_range(0, 2),
                        $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_master_arb.md
Name: ahb_master_arb

Overview:
- Arbitrated AHB-Lite master front-end. Shares one AHB master port between NUM_REQ local requesters, such as the sequencer, a DMA stub and a register-poll engine.
- Issues single, non-pipelined transfers only: address phase, then data phase, then idle.
- Drives the same signal set as the AHB VIP master clocking block (haddr, hwdata, hburst, hsize, hwrite, htrans; samples hready, hrdata). It connects directly to the ahb2apb bridge slave side.

Parameters:
- AHB_DW, 32, data width (32 or 64).
- AHB_AW, 32, address width.
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT, 255, max hready-low cycles in data phase (used only with the optional feature).

Ports:
- clk, in, 1, bus clock.
- reset, in, 1, asynchronous active-high reset.
- req, in, NUM_REQ, per-requester transfer request (level).
- req_write, in, NUM_REQ, 1 = write.
- req_addr, in, NUM_REQ*AHB_AW, packed addresses, requester i at [i*AHB_AW +: AHB_AW].
- req_wdata, in, NUM_REQ*AHB_DW, packed write data.
- req_size, in, NUM_REQ*3, packed hsize codes.
- gnt, out, NUM_REQ, one-hot grant, held for the whole transfer.
- done, out, NUM_REQ, one-cycle completion pulse to the granted requester.
- rdata, out, AHB_DW, read data, valid with done.
- busy, out, 1, high when state != IDLE.
- timeout, out, 1, one-cycle abort pulse.
- haddr, out, AHB_AW.
- hwdata, out, AHB_DW.
- hburst, out, 3.
- hsize, out, 3.
- hwrite, out, 1.
- htrans, out, 2.
- hready, in, 1.
- hrdata, in, AHB_DW.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdata=0, busy=0, timeout=0, haddr=0, hwdata=0, hburst=3'b000, hsize=3'b000, hwrite=0, htrans=2'b00 (IDLE).
- Reset asserted mid-transfer: the transfer is dropped, all outputs go to reset values immediately, no done is issued, and the round-robin pointer returns to NUM_REQ-1.
- hburst is constant 3'b000 (SINGLE). htrans only ever takes IDLE (00) or NONSEQ (10).

State machine (IDLE, ADDR, DATA):
- IDLE → ADDR: any req bit high at a posedge.
  - Winner is chosen round-robin: the first requester with req high, searching upward from last_gnt+1 and wrapping.
  - last_gnt resets to NUM_REQ-1, so req[0] wins first.
  - On that edge: gnt=onehot(winner), busy=1, htrans=NONSEQ, haddr/hwrite/hsize loaded from the winner. The winner's wdata is captured internally.
- ADDR → DATA: posedge with hready=1.
  - On that edge: htrans=IDLE, hwdata=captured wdata. haddr/hsize/hwrite hold their values.
  - hready=0 in ADDR: stay in ADDR and hold all address/control outputs stable.
- DATA → IDLE: posedge with hready=1.
  - On that edge: rdata=hrdata (reads only; writes keep the previous rdata), done[winner]=1 for one cycle, gnt=0, busy=0, last_gnt=winner.
  - hready=0 in DATA: stay in DATA and hold hwdata.
- Minimum latency with zero wait states: req sampled at edge N, done high after edge N+2, i.e. 3 cycles per transfer.
- The earliest next grant is at the edge after done, so IDLE lasts at least one cycle between transfers.
- Requester contract: hold req, req_write, req_addr, req_wdata and req_size stable until done. Deasserting req after grant does not abort; the transfer completes.
- hsize arithmetic:
  - A size code greater than log2(AHB_DW/8) is clamped to that maximum.
  - haddr low bits are forced to zero to the clamped size: 2^size-byte alignment.
- Simultaneous requests are resolved strictly by the round-robin order. A requester re-asserting req in the cycle its done pulses is not eligible until IDLE.

Optional Feature:
- Macro: AHB_MASTER_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8..16-bit counter increments each cycle in DATA while hready=0.
  - When the counter reaches TIMEOUT: timeout=1 for one cycle, done[winner]=1, rdata=0, state returns to IDLE, gnt clears, last_gnt updates.
  - The counter clears on entry to DATA and on reset.
- Without the macro: no counter is built, timeout is tied to 0, and DATA waits on hready indefinitely.

Test Plan:
- Reset then req[0] write, addr 0x0000_1004, size 2, wdata 0xDEAD_BEEF, hready=1 → htrans NONSEQ for 1 cycle with haddr 0x1004 and hwrite=1; hwdata 0xDEADBEEF the next cycle; done[0] 3 cycles after req.
- req[1] read at 0x2000, hready low for 2 cycles in DATA, hrdata 0x1234_5678 → htrans IDLE throughout DATA, hwdata stable, rdata=0x12345678 with done[1] after 5 total cycles.
- req[0] and req[1] both held continuously → grants alternate 0,1,0,1; gnt always one-hot; at least one IDLE cycle between transfers.
- Address 0x1003 with size 2 → haddr 0x1000. Size 3 with AHB_DW=32 → hsize=2, haddr aligned to 4.
- Reset asserted during DATA → htrans, gnt, busy and done all 0 immediately; after release, req[0] wins first.
- With AHB_MASTER_ARB_TIMEOUT_EN and TIMEOUT=4, hready held low in DATA → timeout and done pulse together after 4 wait cycles, rdata=0, busy drops; without the macro, busy stays high.
